// File: rtl/issue_rat_freelist_checkpoint_drain.sv
// Drains a checkpoint bank FIFO into the free list, then clears the bank.
// Optional flush_i abort under ISSUE_RAT_FREELIST_CHECKPOINT_DRAIN_FLUSH_EN.
module issue_rat_freelist_checkpoint_drain #(
  parameter int PRF_WIDTH       = 6,
  parameter int BANK_DEPTH_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_i_valid,
  input  logic                       req_i_abandoned,
  output logic                       req_o_ready,
  input  logic [PRF_WIDTH-1:0]       bank_i_prf,
  input  logic                       bank_i_empty,
  output logic                       bank_o_ren,
  output logic                       bank_o_fifo_reset,
  output logic                       bank_o_tag_wen,
  output logic                       bank_o_tag_valid,
  output logic                       bank_o_tag_abandoned,
  output logic                       fl_o_valid,
  output logic [PRF_WIDTH-1:0]       fl_o_prf,
  input  logic                       fl_i_ready,
`ifdef ISSUE_RAT_FREELIST_CHECKPOINT_DRAIN_FLUSH_EN
  input  logic                       flush_i,
`endif
  output logic [BANK_DEPTH_LOG2:0]   drain_o_count,
  output logic                       busy_o
);

  localparam int CW = BANK_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CMAX = CW'(1 << BANK_DEPTH_LOG2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                 state;
  logic                   out_valid;
  logic [PRF_WIDTH-1:0]   out_prf;
  logic [CW-1:0]          count;
  logic                   flush;
  logic                   hs;
  logic                   ren;

`ifdef ISSUE_RAT_FREELIST_CHECKPOINT_DRAIN_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign hs  = out_valid & fl_i_ready;
  // Only pop when the output register is free or being emptied this cycle.
  assign ren = (state == DRAIN) & ~flush & ~bank_i_empty
             & (~out_valid | fl_i_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_prf   <= '0;
      count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i_valid && !flush) begin
            count <= '0;
            state <= req_i_abandoned ? DRAIN : CLEAR;
          end
        end
        DRAIN: begin
          if (hs && count != CMAX)
            count <= count + 1'b1;
          if (flush) begin
            out_valid <= 1'b0;
            state     <= CLEAR;
          end else begin
            if (ren) begin
              out_prf   <= bank_i_prf;
              out_valid <= 1'b1;
            end else if (hs) begin
              out_valid <= 1'b0;
            end
            if (bank_i_empty && (!out_valid || hs))
              state <= CLEAR;
          end
        end
        CLEAR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_o_ready          = (state == IDLE);
  assign busy_o               = (state != IDLE);
  assign bank_o_ren           = ren;
  assign bank_o_fifo_reset    = (state != CLEAR);
  assign bank_o_tag_wen       = (state == CLEAR);
  assign bank_o_tag_valid     = 1'b0;
  assign bank_o_tag_abandoned = 1'b0;
  assign fl_o_valid           = out_valid;
  assign fl_o_prf             = out_prf;
  assign drain_o_count        = count;

endmodule

// File: doc/issue_rat_freelist_checkpoint_drain.md
ISSUE_RAT_FREELIST_CHECKPOINT_DRAIN -- requirements
Module: issue_rat_freelist_checkpoint_drain

Interface
REQ-001 Parameter PRF_WIDTH, default 6, width of a physical register index.
REQ-002 Parameter BANK_DEPTH_LOG2, default 2, log2 of the checkpoint bank FIFO depth.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_i_valid  input  1  drain request for the attached checkpoint bank.
REQ-006 req_i_abandoned  input  1  1: return stored PRFs to free list; 0: committed, discard them.
REQ-007 req_o_ready  output  1  block idle, request accepted this cycle when both valid and ready.
REQ-008 bank_i_prf  input  PRF_WIDTH  bank FIFO head entry, meaningful when bank_i_empty=0.
REQ-009 bank_i_empty  input  1  bank FIFO empty.
REQ-010 bank_o_ren  output  1  pop bank FIFO head this cycle.
REQ-011 bank_o_fifo_reset  output  1  active-low bank FIFO clear strobe.
REQ-012 bank_o_tag_wen / bank_o_tag_valid / bank_o_tag_abandoned  output  1 each  bank tag write; values written are always 0.
REQ-013 fl_o_valid  output  1  PRF available to free list.
REQ-014 fl_o_prf  output  PRF_WIDTH  PRF returned to free list.
REQ-015 fl_i_ready  input  1  free list accepts fl_o_prf when fl_o_valid=1.
REQ-016 drain_o_count  output  BANK_DEPTH_LOG2+1  PRFs handed to free list since last accepted request.
REQ-017 busy_o  output  1  state is not IDLE.

Function
REQ-018 FSM states IDLE, DRAIN, CLEAR; req_o_ready=1 only in IDLE.
REQ-019 IDLE, request accepted with req_i_abandoned=1 -> DRAIN; with 0 -> CLEAR; drain_o_count cleared to 0 on acceptance.
REQ-020 Output register: out_valid, out_prf; fl_o_valid=out_valid, fl_o_prf=out_prf; no combinational path bank_i_prf -> fl_o_prf.
REQ-021 DRAIN: bank_o_ren = !bank_i_empty & (!out_valid | fl_i_ready); on ren, out_prf<=bank_i_prf, out_valid<=1 next cycle.
REQ-022 Handshake fl_o_valid & fl_i_ready without concurrent ren -> out_valid<=0; drain_o_count increments by 1 per handshake, saturating at 2^BANK_DEPTH_LOG2.
REQ-023 fl_o_valid, once asserted, holds with stable fl_o_prf until accepted.
REQ-024 DRAIN -> CLEAR when bank_i_empty=1 and (out_valid=0 or handshake this cycle); throughput one PRF per cycle with fl_i_ready held high.
REQ-025 CLEAR lasts exactly one cycle: bank_o_fifo_reset=0, bank_o_tag_wen=1, tag_valid=0, tag_abandoned=0; then -> IDLE.
REQ-026 Outside CLEAR: bank_o_fifo_reset=1, bank_o_tag_wen=0; bank_o_ren=0 outside DRAIN.
REQ-027 DRAIN entered with bank already empty -> CLEAR next cycle, no fl_o_valid, count stays 0.
REQ-028 Committed request (req_i_abandoned=0) never asserts bank_o_ren or fl_o_valid.

Reset
REQ-029 reset=0 asynchronously forces IDLE, out_valid=0, out_prf=0, drain_o_count=0.
REQ-030 Under reset outputs: req_o_ready=1, busy_o=0, bank_o_ren=0, bank_o_fifo_reset=1, bank_o_tag_wen=0, fl_o_valid=0.
REQ-031 Reset mid-DRAIN discards held PRF; no CLEAR issued afterwards.

Configuration
REQ-032 Macro ISSUE_RAT_FREELIST_CHECKPOINT_DRAIN_FLUSH_EN defined: adds input flush_i (1 bit); flush_i=1 in DRAIN drops out_valid, stops ren, enters CLEAR next cycle; in IDLE flush_i blocks acceptance that cycle; in CLEAR ignored.
REQ-033 Macro undefined: no flush_i port, DRAIN always runs to completion.

Verification
REQ-034 Bank holds 5,9,12,3; abandoned request, fl_i_ready=1 -> fl_o_prf 5,9,12,3 on consecutive cycles, count=4, one CLEAR cycle, IDLE.
REQ-035 Same bank, committed request -> no ren, no fl_o_valid, CLEAR cycle following acceptance, count=0.
REQ-036 Bank holds 7,8; fl_i_ready low 3 cycles after first valid -> fl_o_prf=7 held stable, single ren outstanding, then 7,8 delivered, count=2.
REQ-037 Empty bank, abandoned request -> CLEAR one cycle after acceptance, fl_o_valid never 1.
REQ-038 reset low during DRAIN after 2 of 4 PRFs -> immediately IDLE, fl_o_valid=0, count=0, bank_o_fifo_reset stays 1.
REQ-039 FLUSH_EN build, flush_i pulse after first PRF delivered -> fl_o_valid drops, CLEAR next cycle, count=1.
